// File: rtl/mouse_dev_pkg.sv
// Shared state encoding and PS/2 mouse command/response byte values.
package mouse_dev_pkg;

  typedef enum logic [3:0] {
    ST_SELFTEST, ST_TX_AA, ST_TX_ID, ST_IDLE,
    ST_TX_ACK, ST_TX_RESP, ST_PKT0, ST_PKT1, ST_PKT2
  } state_t;

  // Follow-up work once the ACK byte has gone out
  typedef enum logic [1:0] {ACT_NONE, ACT_RESET, ACT_ID} act_t;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_DISABLE  = 8'hF5;
  localparam logic [7:0] CMD_DEFAULTS = 8'hF6;
  localparam logic [7:0] CMD_GET_ID   = 8'hF2;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

endpackage

// File: rtl/mouse_move_accum.sv
// Saturating X/Y movement accumulators (axis 0 = X, axis 1 = Y) with sticky overflow flags.
module mouse_move_accum #(
  parameter int ACC_W = 10
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            clr,
  input  logic            add,
  input  logic [1:0][7:0] delta,
  output logic [1:0][8:0] pos,
  output logic [1:0]      ovf
);

  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(255);
  localparam logic signed [ACC_W:0] MINV = -(ACC_W+1)'(256);

  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic signed [ACC_W-1:0] acc, base;
    logic signed [ACC_W:0]   sum;
    logic                    sat_hi, sat_lo, ovf_r;

    // clr and add together: the delta lands on the freshly cleared value
    always_comb begin
      base   = clr ? '0 : acc;
      sum    = {base[ACC_W-1], base} + {{(ACC_W-7){delta[a][7]}}, delta[a]};
      sat_hi = sum > MAXV;
      sat_lo = sum < MINV;
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        acc   <= '0;
        ovf_r <= 1'b0;
      end else if (add) begin
        acc   <= sat_hi ? MAXV[ACC_W-1:0] : sat_lo ? MINV[ACC_W-1:0] : sum[ACC_W-1:0];
        ovf_r <= (ovf_r & ~clr) | sat_hi | sat_lo;
      end else if (clr) begin
        acc   <= '0;
        ovf_r <= 1'b0;
      end
    end

    assign pos[a] = acc[8:0];
    assign ovf[a] = ovf_r;
  end

endmodule

// File: rtl/mouse_device_sm.sv
// Device-side PS/2 mouse engine: power-on BAT, host command responses and 3-byte stream packets.
module mouse_device_sm
  import mouse_dev_pkg::*;
#(
  parameter int SELFTEST_CYCLES = 500000,
  parameter int ACC_W           = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CMD_BYTE,
  input  logic       CMD_READY,
  input  logic [1:0] CMD_ERROR,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [7:0] MOVE_DX,
  input  logic [7:0] MOVE_DY,
  input  logic [2:0] MOVE_BTN,
  output logic       STREAM_EN,
  output logic [3:0] STATE_DBG
);

  localparam int CNT_W = $clog2(SELFTEST_CYCLES + 1);

  state_t           state;
  act_t             act;
  logic [CNT_W-1:0] cnt;
  logic             req_done, cmd_pend;
  logic [7:0]       pend_byte, pkt1, pkt2;
  logic [1:0]       pend_err;
  logic [2:0]       last_btn;

  logic [1:0][8:0]  pos;
  logic [1:0]       ovf;
  logic             is_tx, sent, service, trigger, acc_clr;
  logic [7:0]       byte0;

  always_comb begin
    is_tx   = state inside {ST_TX_AA, ST_TX_ID, ST_TX_ACK, ST_TX_RESP, ST_PKT0, ST_PKT1, ST_PKT2};
    sent    = is_tx && req_done && BYTE_SENT;
    service = (state == ST_IDLE) && cmd_pend;
    trigger = (state == ST_IDLE) && STREAM_EN && !cmd_pend && !CMD_READY &&
              (pos[0] != '0 || pos[1] != '0 || MOVE_BTN != last_btn);
    acc_clr = trigger || (service && pend_err == 2'd0 &&
              (pend_byte == CMD_RESET || pend_byte == CMD_DISABLE));
    byte0   = {ovf[1], ovf[0], pos[1][8], pos[0][8], 1'b1, MOVE_BTN};
  end

  mouse_move_accum #(.ACC_W(ACC_W)) u_accum (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (acc_clr),
    .add   (MOVE_VALID && STREAM_EN),
    .delta ({MOVE_DY, MOVE_DX}),
    .pos   (pos),
    .ovf   (ovf)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_SELFTEST;
      act          <= ACT_NONE;
      cnt          <= '0;
      req_done     <= 1'b0;
      cmd_pend     <= 1'b0;
      pend_byte    <= 8'h00;
      pend_err     <= 2'd0;
      pkt1         <= 8'h00;
      pkt2         <= 8'h00;
      last_btn     <= 3'b000;
      SEND_BYTE    <= 1'b0;
      BYTE_TO_SEND <= 8'h00;
      STREAM_EN    <= 1'b0;
    end else begin
      SEND_BYTE <= 1'b0;
      if (is_tx && !req_done) begin
        SEND_BYTE <= 1'b1;
        req_done  <= 1'b1;
      end
      case (state)
        ST_SELFTEST: begin
          cmd_pend <= 1'b0;
          if (cnt == CNT_W'(SELFTEST_CYCLES - 1)) begin
            cnt <= '0; state <= ST_TX_AA; BYTE_TO_SEND <= RSP_BAT_OK; req_done <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_TX_AA: if (sent) begin
          state <= ST_TX_ID; BYTE_TO_SEND <= RSP_ID; req_done <= 1'b0;
        end
        ST_TX_ID, ST_TX_RESP, ST_PKT2: if (sent) state <= ST_IDLE;
        ST_IDLE: begin
          if (service) begin
            cmd_pend     <= 1'b0;
            state        <= ST_TX_ACK;
            req_done     <= 1'b0;
            act          <= ACT_NONE;
            BYTE_TO_SEND <= RSP_ACK;
            if (pend_err != 2'd0) BYTE_TO_SEND <= RSP_RESEND;
            else case (pend_byte)
              CMD_RESET:    begin act <= ACT_RESET; STREAM_EN <= 1'b0; end
              CMD_ENABLE:   STREAM_EN <= 1'b1;
              CMD_DISABLE,
              CMD_DEFAULTS: STREAM_EN <= 1'b0;
              CMD_GET_ID:   act <= ACT_ID;
              default:      BYTE_TO_SEND <= RSP_RESEND;
            endcase
          end else if (trigger) begin
            pkt1 <= pos[0][7:0]; pkt2 <= pos[1][7:0]; last_btn <= MOVE_BTN;
            state <= ST_PKT0; BYTE_TO_SEND <= byte0; req_done <= 1'b0;
          end
        end
        ST_TX_ACK: if (sent) begin
          act <= ACT_NONE;
          case (act)
            ACT_RESET: begin state <= ST_SELFTEST; cnt <= '0; end
            ACT_ID:    begin state <= ST_TX_RESP; BYTE_TO_SEND <= RSP_ID; req_done <= 1'b0; end
            default:   state <= ST_IDLE;
          endcase
        end
        // A host command preempts the rest of an in-flight packet
        ST_PKT0: if (sent) begin
          if (cmd_pend || CMD_READY) state <= ST_IDLE;
          else begin state <= ST_PKT1; BYTE_TO_SEND <= pkt1; req_done <= 1'b0; end
        end
        ST_PKT1: if (sent) begin
          if (cmd_pend || CMD_READY) state <= ST_IDLE;
          else begin state <= ST_PKT2; BYTE_TO_SEND <= pkt2; req_done <= 1'b0; end
        end
        default: state <= ST_SELFTEST;
      endcase
      if (CMD_READY && state != ST_SELFTEST) begin
        cmd_pend  <= 1'b1;
        pend_byte <= CMD_BYTE;
        pend_err  <= CMD_ERROR;
      end
    end
  end

  assign STATE_DBG = state;

endmodule

// File: tb/tb_mouse_device_sm.sv
// Bench for mouse_device_sm: transmitter model pops expected bytes from a scoreboard queue.
module tb_mouse_device_sm;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] CMD_BYTE;
  logic       CMD_READY;
  logic [1:0] CMD_ERROR;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       MOVE_VALID;
  logic [7:0] MOVE_DX, MOVE_DY;
  logic [2:0] MOVE_BTN;
  logic       STREAM_EN;
  logic [3:0] STATE_DBG;

  mouse_device_sm #(.SELFTEST_CYCLES(50), .ACC_W(10)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_BYTE(CMD_BYTE), .CMD_READY(CMD_READY),
    .CMD_ERROR(CMD_ERROR), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .MOVE_VALID(MOVE_VALID), .MOVE_DX(MOVE_DX),
    .MOVE_DY(MOVE_DY), .MOVE_BTN(MOVE_BTN), .STREAM_EN(STREAM_EN), .STATE_DBG(STATE_DBG)
  );

  always #5 CLK = ~CLK;

  localparam int S_SELFTEST = 0;
  localparam int S_IDLE     = 3;

  typedef struct {
    logic [7:0] cmd;
    logic [1:0] err;
    int         nrsp;
    logic [7:0] r0;
    logic [7:0] r1;
    logic       stream;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] expq[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         tx_lat = 3;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model: accept each request, compare, then acknowledge after tx_lat cycles
  initial begin
    BYTE_SENT = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET && SEND_BYTE) begin
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_byte: got 0x%02h, want no byte", BYTE_TO_SEND);
        end else begin
          chk("tx_byte", int'(BYTE_TO_SEND), int'(expq.pop_front()));
        end
        repeat (tx_lat) @(negedge CLK);
        BYTE_SENT = 1'b1;
        @(negedge CLK);
        BYTE_SENT = 1'b0;
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (expq.size() != 0 && t < 5000) begin @(negedge CLK); t++; end
    chk("drain_left", expq.size(), 0);
    expq.delete();
    repeat (tx_lat + 10) @(negedge CLK);
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic [1:0] e);
    @(negedge CLK);
    CMD_BYTE = b; CMD_ERROR = e; CMD_READY = 1'b1;
    @(negedge CLK);
    CMD_READY = 1'b0; CMD_ERROR = 2'd0;
  endtask

  task automatic move(input logic [7:0] dx, input logic [7:0] dy);
    @(negedge CLK);
    MOVE_DX = dx; MOVE_DY = dy; MOVE_VALID = 1'b1;
    @(negedge CLK);
    MOVE_VALID = 1'b0;
  endtask

  task automatic wait_q(input int sz);
    int t = 0;
    while (expq.size() != sz && t < 2000) begin @(negedge CLK); t++; end
    chk("wait_queue", expq.size(), sz);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'hF4, 2'd0, 1, 8'hFA, 8'h00, 1'b1};
    vecs[1] = '{8'hAB, 2'd0, 1, 8'hFE, 8'h00, 1'b1};
    vecs[2] = '{8'hF2, 2'd0, 2, 8'hFA, 8'h00, 1'b1};
    vecs[3] = '{8'hF4, 2'd1, 1, 8'hFE, 8'h00, 1'b1};
    vecs[4] = '{8'hF6, 2'd0, 1, 8'hFA, 8'h00, 1'b0};
    vecs[5] = '{8'hF5, 2'd0, 1, 8'hFA, 8'h00, 1'b0};
    vecs[6] = '{8'hF4, 2'd0, 1, 8'hFA, 8'h00, 1'b1};

    RESET = 1'b0; CMD_BYTE = 8'h00; CMD_READY = 1'b0; CMD_ERROR = 2'd0;
    MOVE_VALID = 1'b0; MOVE_DX = 8'h00; MOVE_DY = 8'h00; MOVE_BTN = 3'b000;
    repeat (3) @(negedge CLK);
    chk("rst_send", SEND_BYTE, 0);
    chk("rst_byte", BYTE_TO_SEND, 0);
    chk("rst_stream", STREAM_EN, 0);
    chk("rst_state", STATE_DBG, S_SELFTEST);

    // Power-on: 0xAA request on the 51st edge after release, then 0x00
    expq.push_back(8'hAA); expq.push_back(8'h00);
    RESET = 1'b1;
    n = 0;
    while (!SEND_BYTE && n < 200) begin @(posedge CLK); #1; n++; end
    chk("bat_latency", n, 51);
    drain();
    chk("por_stream", STREAM_EN, 0);
    chk("por_state", STATE_DBG, S_IDLE);

    foreach (vecs[i]) begin
      expq.push_back(vecs[i].r0);
      if (vecs[i].nrsp == 2) expq.push_back(vecs[i].r1);
      send_cmd(vecs[i].cmd, vecs[i].err);
      drain();
      chk("cmd_stream", STREAM_EN, vecs[i].stream);
    end

    // Movement with L pressed as the packet fires
    expq.push_back(8'h29); expq.push_back(8'h05); expq.push_back(8'hFD);
    move(8'd5, 8'hFD);
    MOVE_BTN = 3'b001;
    drain();
    // Button release alone triggers a packet
    expq.push_back(8'h08); expq.push_back(8'h00); expq.push_back(8'h00);
    MOVE_BTN = 3'b000;
    drain();

    // Deltas during snapshot and while busy accumulate, saturating at +255
    expq.push_back(8'h08); expq.push_back(8'h01); expq.push_back(8'h00);
    expq.push_back(8'h48); expq.push_back(8'hFF); expq.push_back(8'h00);
    @(negedge CLK);
    MOVE_DX = 8'd1; MOVE_DY = 8'd0; MOVE_VALID = 1'b1;
    @(negedge CLK);
    MOVE_DX = 8'd100;
    repeat (3) @(negedge CLK);
    MOVE_VALID = 1'b0;
    drain();

    // Reset command while byte0 is in flight: packet cut short, full power-on replayed
    tx_lat = 20;
    expq.push_back(8'h08); expq.push_back(8'hFA); expq.push_back(8'hAA); expq.push_back(8'h00);
    move(8'd2, 8'd0);
    wait_q(3);
    send_cmd(8'hFF, 2'd0);
    drain();
    tx_lat = 3;
    chk("ff_stream", STREAM_EN, 0);
    chk("ff_state", STATE_DBG, S_IDLE);

    // Async reset while byte1 is in flight
    expq.push_back(8'hFA);
    send_cmd(8'hF4, 2'd0);
    drain();
    expq.push_back(8'h08); expq.push_back(8'h03); expq.push_back(8'h00);
    move(8'd3, 8'd0);
    wait_q(1);
    RESET = 1'b0;
    #1;
    chk("midrst_send", SEND_BYTE, 0);
    chk("midrst_stream", STREAM_EN, 0);
    chk("midrst_state", STATE_DBG, S_SELFTEST);
    expq.delete();
    expq.push_back(8'hAA); expq.push_back(8'h00);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    send_cmd(8'hF4, 2'd0);
    drain();
    chk("midrst_por_stream", STREAM_EN, 0);
    chk("midrst_por_state", STATE_DBG, S_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mouse_device_sm.md
Name: mouse_device_sm

Overview:
- Device-side (mouse-end) PS/2 protocol engine, the responder counterpart to the host-side mouse master state machine.
- Decodes host command bytes from a device-side PS/2 byte receiver, returns the protocol responses, and streams 3-byte movement packets through a device-side byte transmitter.
- Serves as the board-level mouse emulator and as the bench model for host-side verification.

Parameters:
- SELFTEST_CYCLES, 500000: self-test delay in CLK cycles before 0xAA is sent (10 ms at 50 MHz).
- ACC_W, 10: internal signed movement accumulator width.

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-low reset
- CMD_BYTE  input  8  byte received from the host
- CMD_READY  input  1  one-cycle pulse; CMD_BYTE/CMD_ERROR valid
- CMD_ERROR  input  2  receiver error code; 0 = good
- SEND_BYTE  output  1  one-cycle request to the transmitter
- BYTE_TO_SEND  output  8  byte to transmit; held stable until BYTE_SENT
- BYTE_SENT  input  1  one-cycle pulse; transmission complete
- MOVE_VALID  input  1  one-cycle movement sample strobe
- MOVE_DX  input  8  signed X delta
- MOVE_DY  input  8  signed Y delta
- MOVE_BTN  input  3  {M,R,L} button levels, sampled every cycle
- STREAM_EN  output  1  data reporting enabled
- STATE_DBG  output  4  encoded current state

Behaviour:
- Reset values: SEND_BYTE=0, BYTE_TO_SEND=0x00, STREAM_EN=0, accumulators=0, overflow flags=0, last_btn=0, state=ST_SELFTEST, delay counter=0.
- States:
  - ST_SELFTEST: counts to SELFTEST_CYCLES-1, then goes to ST_TX_AA.
  - ST_TX_AA: sends 0xAA, then ST_TX_ID.
  - ST_TX_ID: sends 0x00, then ST_IDLE.
  - ST_IDLE: waits for a command or a packet trigger.
  - ST_TX_ACK: sends 0xFA or 0xFE.
  - ST_TX_RESP: sends a command's extra byte.
  - ST_PKT0, ST_PKT1, ST_PKT2: send the three packet bytes.
- Send handshake: on entry to any TX state, SEND_BYTE pulses high for exactly 1 cycle in the cycle after entry, with BYTE_TO_SEND already valid. The state advances in the cycle after BYTE_SENT. No re-request occurs until BYTE_SENT.
- Command decode (CMD_READY in ST_IDLE or any TX state):
  - CMD_ERROR != 0: respond 0xFE.
  - 0xFF (reset): 0xFA, then STREAM_EN=0, accumulators cleared, ST_SELFTEST.
  - 0xF4 (enable): 0xFA, STREAM_EN=1.
  - 0xF5 (disable): 0xFA, STREAM_EN=0, accumulators cleared.
  - 0xF6 (set defaults): 0xFA, STREAM_EN=0.
  - 0xF2 (get ID): 0xFA, then 0x00.
  - Any other value: 0xFE.
- Command during ST_SELFTEST: ignored.
- Command during a TX state: latched in a 1-deep buffer. The in-flight byte completes (wait for BYTE_SENT), the remaining packet bytes are discarded, then the command is serviced. A second command before service overwrites the buffer.
- Packet trigger, evaluated only in ST_IDLE with STREAM_EN=1 and no pending command: fires when accumulator X != 0, Y != 0, or MOVE_BTN != last_btn.
- On trigger, in a single cycle:
  - snapshot status, dx and dy into a packet register;
  - clear the accumulators and overflow flags;
  - set last_btn = MOVE_BTN.
- Packet bytes:
  - byte0 = {Y_OVF, X_OVF, Y_SIGN, X_SIGN, 1'b1, M, R, L};
  - byte1 = X[7:0];
  - byte2 = Y[7:0].
- Accumulation:
  - MOVE_VALID adds the sign-extended delta, but only when STREAM_EN=1; when STREAM_EN=0 it is dropped.
  - Results are saturated to the 9-bit range [-256, +255]; saturating sets the matching OVF flag.
  - SIGN = bit 8 of the saturated value.
- MOVE_VALID in the snapshot cycle: the delta is added to the freshly cleared accumulator and is not lost.
- Pending command and trigger in the same cycle: the command wins.
- RESET asserted mid-operation: everything returns to reset values immediately and the power-on sequence is replayed.

Decomposition:
- Package mouse_dev_pkg:
  - state enum;
  - command constants CMD_RESET 0xFF, CMD_ENABLE 0xF4, CMD_DISABLE 0xF5, CMD_DEFAULTS 0xF6, CMD_GET_ID 0xF2;
  - response constants RSP_ACK 0xFA, RSP_RESEND 0xFE, RSP_BAT_OK 0xAA, RSP_ID 0x00.
- Sub-module mouse_move_accum:
  - saturating X/Y accumulators and overflow flags;
  - inputs: clear, add strobe;
  - outputs: packet fields.

Test Plan:
- Power-on, SELFTEST_CYCLES=50 → SEND_BYTE with 0xAA at cycle 51, then 0x00 after BYTE_SENT; STREAM_EN stays 0.
- Host sends 0xF4 → 0xFA sent, STREAM_EN=1. Then MOVE_DX=+5, MOVE_DY=-3, L pressed → bytes 0x29, 0x05, 0xFD.
- STREAM_EN=1, three MOVE_VALID with DX=+100, DY=0 → bytes 0x48, 0xFF, 0x00.
- Host sends 0xAB → 0xFE; host sends 0xF2 → 0xFA then 0x00; CMD_READY with CMD_ERROR=2'b01 → 0xFE.
- Host sends 0xFF while the transmitter is busy with ST_PKT0 → byte0 completes, bytes 1-2 dropped, 0xFA sent, then SELFTEST delay, 0xAA, 0x00, STREAM_EN=0.
- RESET pulsed low during ST_PKT1 → SEND_BYTE=0, STREAM_EN=0 immediately; power-on sequence repeats.
